// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC controller: owns the PC, issues requests to instruction memory
// over a ready/valid handshake, and applies branch/jump redirects from decode.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        branch_d,
    input  logic        jump_d,
    input  logic [31:0] pc_plus4_d,
    input  logic [31:0] imm_d,
    input  logic [25:0] instr_index_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f,
    output logic        fetch_valid_f,
    output logic        flush_d,
    output logic [1:0]  state_dbg_o
);

    // Handshake: a request is outstanding while imem_req=1; it completes in the
    // cycle imem_ready=1. imem_addr is held stable until that cycle.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        redirect;
    logic [31:0] target;

    assign redirect = (branch_d | jump_d) & ~stall_f;
    assign target   = jump_d ? {pc_plus4_d[31:28], instr_index_d, 2'b00}
                             : pc_plus4_d + {imm_d[29:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (imem_ready) begin
                    if (redirect)      pc_d = target;
                    else if (!stall_f) pc_d = pc_q + 32'd4;
                end else if (redirect) begin
                    // Request still outstanding: park the target until it completes.
                    pend_pc_d = target;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect) pend_pc_d = target;
                if (imem_ready) begin
                    pc_d    = redirect ? target : pend_pc_q;
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        imem_req      = 1'b0;
        fetch_valid_f = 1'b0;
        flush_d       = 1'b0;
        case (state_q)
            REQ: begin
                imem_req      = 1'b1;
                fetch_valid_f = imem_ready & ~redirect & ~stall_f;
                flush_d       = redirect;
            end
            DRAIN: begin
                imem_req = 1'b1;
                flush_d  = redirect;
            end
            default: ;
        endcase
    end

    assign pc_f        = pc_q;
    assign imem_addr   = pc_q;
    assign pc_plus4_f  = pc_q + 32'd4;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: a cycle-by-cycle vector table from reset,
// followed by an asynchronous reset applied while a redirect is parked in DRAIN.
module tb_fetch_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall_f;
    logic        branch_d;
    logic        jump_d;
    logic [31:0] pc_plus4_d;
    logic [31:0] imm_d;
    logic [25:0] instr_index_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        fetch_valid_f;
    logic        flush_d;
    logic [1:0]  state_dbg_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rdy;
        logic        stall;
        logic        br;
        logic        jp;
        logic [31:0] pc4d;
        logic [31:0] imm;
        logic [25:0] idx;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_fv;
        logic        exp_fl;
    } vec_t;

    vec_t vecs[$];

    fetch_pc_sequencer #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_f       (stall_f),
        .branch_d      (branch_d),
        .jump_d        (jump_d),
        .pc_plus4_d    (pc_plus4_d),
        .imm_d         (imm_d),
        .instr_index_d (instr_index_d),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .pc_f          (pc_f),
        .pc_plus4_f    (pc_plus4_f),
        .fetch_valid_f (fetch_valid_f),
        .flush_d       (flush_d),
        .state_dbg_o   (state_dbg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rdy, input logic stall, input logic br, input logic jp,
                           input logic [31:0] pc4d, input logic [31:0] imm, input logic [25:0] idx,
                           input logic ereq, input logic [31:0] eaddr, input logic efv, input logic efl);
        vec_t v;
        v.rdy = rdy; v.stall = stall; v.br = br; v.jp = jp;
        v.pc4d = pc4d; v.imm = imm; v.idx = idx;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_fv = efv; v.exp_fl = efl;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rdy, input logic stall, input logic br, input logic jp,
                         input logic [31:0] pc4d, input logic [31:0] imm, input logic [25:0] idx);
        imem_ready    = rdy;
        stall_f       = stall;
        branch_d      = br;
        jump_d        = jp;
        pc_plus4_d    = pc4d;
        imm_d         = imm;
        instr_index_d = idx;
    endtask

    task automatic check_outputs(input string tag, input logic ereq, input logic [31:0] eaddr,
                                 input logic efv, input logic efl);
        logic [31:0] exp_p4;
        exp_p4 = eaddr + 32'd4;
        check1 ({tag, " imem_req"},      imem_req,      ereq);
        check32({tag, " imem_addr"},     imem_addr,     eaddr);
        check32({tag, " pc_f"},          pc_f,          eaddr);
        check32({tag, " pc_plus4_f"},    pc_plus4_f,    exp_p4);
        check1 ({tag, " fetch_valid_f"}, fetch_valid_f, efv);
        check1 ({tag, " flush_d"},       flush_d,       efl);
    endtask

    initial begin
        // Cycle-by-cycle sequence starting in the BOOT cycle after reset release.
        //       rdy   stl   br    jp    pc_plus4_d    imm_d         idx           req   addr          fv    fl
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b0, 32'hBFC00000, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'hBFC00000, 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'hBFC00004, 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'hBFC00008, 1'b1, 1'b0);
        // backward branch: 0x00400010 + (-4 << 2) = 0x00400000
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 32'h00400010, 32'hFFFFFFFC, 26'h0,        1'b1, 32'hBFC0000C, 1'b0, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'h00400000, 1'b1, 1'b0);
        // branch and jump together: jump target wins
        add_vec(1'b1, 1'b0, 1'b1, 1'b1, 32'hA0000100, 32'h00000010, 26'h0000040,  1'b1, 32'h00400004, 1'b0, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'hA0000100, 1'b1, 1'b0);
        // three stalled cycles with a pending branch, then release
        add_vec(1'b1, 1'b1, 1'b1, 1'b0, 32'h00400010, 32'h00000004, 26'h0,        1'b1, 32'hA0000104, 1'b0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b1, 1'b0, 32'h00400010, 32'h00000004, 26'h0,        1'b1, 32'hA0000104, 1'b0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b1, 1'b0, 32'h00400010, 32'h00000004, 26'h0,        1'b1, 32'hA0000104, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 32'h00400010, 32'h00000004, 26'h0,        1'b1, 32'hA0000104, 1'b0, 1'b1);
        // wait-state memory: two jumps while waiting, newest (0x00400200) wins
        add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'h00400024, 32'h0,        26'h0100040,  1'b1, 32'h00400020, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'h00400024, 32'h0,        26'h0100080,  1'b1, 32'h00400020, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'h00400020, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'h00400020, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'h00400200, 1'b1, 1'b0);
        // plain wait state without redirect
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'h00400204, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'h00400204, 1'b1, 1'b0);
        // branch while waiting, then a jump in the very cycle memory completes
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 32'h00400100, 32'h00000008, 26'h0,        1'b1, 32'h00400208, 1'b0, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 32'h10000000, 32'h0,        26'h0000010,  1'b1, 32'h00400208, 1'b0, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'h10000040, 1'b1, 1'b0);
        // branch target wraps past 2^32
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF0, 32'h00000008, 26'h0,        1'b1, 32'h10000044, 1'b0, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'h00000010, 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'h00000014, 1'b1, 1'b0);
        // jump to the top word; pc_plus4_f and the next fetch wrap to zero
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 32'hF0000000, 32'h0,        26'h3FFFFFF,  1'b1, 32'h00000018, 1'b0, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'hFFFFFFFC, 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        26'h0,        1'b1, 32'h00000000, 1'b1, 1'b0);

        // Reset with a redirect presented: must stay quiet.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h00400010, 32'h4, 26'h0);
        repeat (2) @(negedge clk);
        #2;
        check_outputs("reset", 1'b0, 32'hBFC00000, 1'b0, 1'b0);
        check32("reset state", {30'b0, state_dbg_o}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            drive(vecs[i].rdy, vecs[i].stall, vecs[i].br, vecs[i].jp,
                  vecs[i].pc4d, vecs[i].imm, vecs[i].idx);
            #2;
            check_outputs($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                          vecs[i].exp_fv, vecs[i].exp_fl);
        end

        // Park a jump to 0x00000400 in DRAIN, then reset asynchronously mid-cycle.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 26'h0000100);
        #2;
        check_outputs("drain entry", 1'b1, 32'h00000004, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0);
        #2;
        check32("drain state", {30'b0, state_dbg_o}, 32'd2);
        check_outputs("drain hold", 1'b1, 32'h00000004, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_outputs("async reset", 1'b0, 32'hBFC00000, 1'b0, 1'b0);
        check32("async reset state", {30'b0, state_dbg_o}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0);
        #2;
        check_outputs("reboot boot", 1'b0, 32'hBFC00000, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        check_outputs("reboot fetch0", 1'b1, 32'hBFC00000, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        check_outputs("reboot fetch1", 1'b1, 32'hBFC00004, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
